// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - branch request/result bundle between decode and the branch resolve unit
//
// Purpose: groups the decode-stage branch request (operands, readiness, PC,
// offset, prediction, flush) and the registered resolution result.
// Signal suffixes are relative to the resolve unit (_i into it, _o out of it).
//   valid_i, b_sel_i, opa_i, opb_i, opa_rdy_i, opb_rdy_i,
//   pc_i, imm16_i, pred_i, flush_i            : request from decode
//   stall_o                                    : combinational hold for D
//   res_valid_o, taken_o, link_o, mispredict_o,
//   target_o, link_addr_o                      : registered result
// Modports: master = decode side, slave = resolve unit.

interface branch_resolve_unit_if #(
    parameter int DATA_W = 32
);
    logic              valid_i;
    logic [3:0]        b_sel_i;
    logic [DATA_W-1:0] opa_i;
    logic [DATA_W-1:0] opb_i;
    logic              opa_rdy_i;
    logic              opb_rdy_i;
    logic [31:0]       pc_i;
    logic [15:0]       imm16_i;
    logic              pred_i;
    logic              flush_i;
    logic              stall_o;
    logic              res_valid_o;
    logic              taken_o;
    logic              link_o;
    logic              mispredict_o;
    logic [31:0]       target_o;
    logic [31:0]       link_addr_o;

    modport master (
        output valid_i, b_sel_i, opa_i, opb_i, opa_rdy_i, opb_rdy_i,
               pc_i, imm16_i, pred_i, flush_i,
        input  stall_o, res_valid_o, taken_o, link_o, mispredict_o,
               target_o, link_addr_o
    );

    modport slave (
        input  valid_i, b_sel_i, opa_i, opb_i, opa_rdy_i, opb_rdy_i,
               pc_i, imm16_i, pred_i, flush_i,
        output stall_o, res_valid_o, taken_o, link_o, mispredict_o,
               target_o, link_addr_o
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - decode-stage branch compare, target/link generation, BHT and statistics
//
// Purpose: resolves a branch in D once the operands it needs are forwarded,
// registers the decision one cycle later with a mispredict flag, keeps
// saturating branch/mispredict counters and an optional 2-bit BHT.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   br (slave)        : branch request / registered result bundle
//   fetch_pc_i        : fetch PC for the BHT lookup
//   pred_taken_o      : combinational BHT prediction for fetch_pc_i
//   br_cnt_o, mp_cnt_o: resolved-branch and mispredict counters
// Build option: define BRU_BHT_EN to include the branch history table;
// without it pred_taken_o is tied to 0.

module branch_resolve_unit #(
    parameter int DATA_W    = 32,
    parameter int BHT_IDX_W = 4,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    branch_resolve_unit_if.slave br,
    input  logic [31:0]         fetch_pc_i,
    output logic                pred_taken_o,
    output logic [CNT_W-1:0]    br_cnt_o,
    output logic [CNT_W-1:0]    mp_cnt_o
);
    // Mode encodings of b_sel_i
    localparam logic [3:0] M_BEQ    = 4'd0;
    localparam logic [3:0] M_BGEZAL = 4'd1;
    localparam logic [3:0] M_BNE    = 4'd2;
    localparam logic [3:0] M_BGEZ   = 4'd3;
    localparam logic [3:0] M_BLTZ   = 4'd4;
    localparam logic [3:0] M_BGTZ   = 4'd5;
    localparam logic [3:0] M_BLEZ   = 4'd6;
    localparam logic [3:0] M_BLTZAL = 4'd7;

    logic        need_b;
    logic        ops_rdy;
    logic        accept;
    logic        taken_c;
    logic        link_c;
    logic        a_neg;
    logic        a_zero;
    logic [31:0] imm_ext;

    logic              res_valid_q, res_valid_d;
    logic              taken_q, taken_d;
    logic              link_q, link_d;
    logic              mp_q, mp_d;
    logic [31:0]       target_q, target_d;
    logic [31:0]       link_addr_q, link_addr_d;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]  mp_cnt_q, mp_cnt_d;

    // Only the two-register compares wait on rt; everything else, reserved
    // modes included, waits on rs alone.
    assign need_b  = (br.b_sel_i == M_BEQ) || (br.b_sel_i == M_BNE);
    assign ops_rdy = br.opa_rdy_i & (br.opb_rdy_i | ~need_b);

    assign br.stall_o = ~reset & br.valid_i & ~br.flush_i & ~ops_rdy;
    assign accept     = ~reset & br.valid_i & ~br.flush_i & ops_rdy;

    // Signed compares against zero reduce to sign bit and zero detect.
    assign a_neg  = br.opa_i[DATA_W-1];
    assign a_zero = (br.opa_i == '0);

    always_comb begin
        taken_c = 1'b0;
        case (br.b_sel_i)
            M_BEQ:             taken_c = (br.opa_i == br.opb_i);
            M_BNE:             taken_c = (br.opa_i != br.opb_i);
            M_BGEZ, M_BGEZAL:  taken_c = ~a_neg;
            M_BLTZ, M_BLTZAL:  taken_c = a_neg;
            M_BGTZ:            taken_c = ~a_neg & ~a_zero;
            M_BLEZ:            taken_c = a_neg | a_zero;
            default:           taken_c = 1'b0;
        endcase
    end

    // Link modes write $ra regardless of the outcome.
    assign link_c  = (br.b_sel_i == M_BGEZAL) || (br.b_sel_i == M_BLTZAL);
    assign imm_ext = {{14{br.imm16_i[15]}}, br.imm16_i, 2'b00};

    always_comb begin
        res_valid_d = accept;
        taken_d     = taken_q;
        link_d      = link_q;
        mp_d        = mp_q;
        target_d    = target_q;
        link_addr_d = link_addr_q;
        br_cnt_d    = br_cnt_q;
        mp_cnt_d    = mp_cnt_q;
        if (accept) begin
            taken_d     = taken_c;
            link_d      = link_c;
            mp_d        = taken_c ^ br.pred_i;
            target_d    = br.pc_i + 32'd4 + imm_ext;
            link_addr_d = br.pc_i + 32'd8;
            if (br_cnt_q != '1) begin
                br_cnt_d = br_cnt_q + 1'b1;
            end
            if ((taken_c ^ br.pred_i) && (mp_cnt_q != '1)) begin
                mp_cnt_d = mp_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_valid_q <= 1'b0;
            taken_q     <= 1'b0;
            link_q      <= 1'b0;
            mp_q        <= 1'b0;
            target_q    <= '0;
            link_addr_q <= '0;
            br_cnt_q    <= '0;
            mp_cnt_q    <= '0;
        end else begin
            res_valid_q <= res_valid_d;
            taken_q     <= taken_d;
            link_q      <= link_d;
            mp_q        <= mp_d;
            target_q    <= target_d;
            link_addr_q <= link_addr_d;
            br_cnt_q    <= br_cnt_d;
            mp_cnt_q    <= mp_cnt_d;
        end
    end

    assign br.res_valid_o  = res_valid_q;
    assign br.taken_o      = taken_q;
    assign br.link_o       = link_q;
    assign br.mispredict_o = mp_q;
    assign br.target_o     = target_q;
    assign br.link_addr_o  = link_addr_q;
    assign br_cnt_o        = br_cnt_q;
    assign mp_cnt_o        = mp_cnt_q;

`ifdef BRU_BHT_EN
    localparam int BHT_N = 1 << BHT_IDX_W;

    logic [1:0]           bht_q [BHT_N];
    logic [BHT_IDX_W-1:0] upd_idx;
    logic [BHT_IDX_W-1:0] rd_idx;

    assign upd_idx = br.pc_i[BHT_IDX_W+1:2];
    assign rd_idx  = fetch_pc_i[BHT_IDX_W+1:2];

    // Read straight from the registers, so a same-cycle update to the
    // entry fetch is looking at is not yet visible.
    assign pred_taken_o = bht_q[rd_idx][1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (accept) begin
            if (taken_c && (bht_q[upd_idx] != 2'b11)) begin
                bht_q[upd_idx] <= bht_q[upd_idx] + 2'd1;
            end else if (!taken_c && (bht_q[upd_idx] != 2'b00)) begin
                bht_q[upd_idx] <= bht_q[upd_idx] - 2'd1;
            end
        end
    end
`else
    assign pred_taken_o = 1'b0;
`endif

    // Bits of fetch_pc_i outside the table index are architecturally ignored.
    logic unused_fetch_pc;
    assign unused_fetch_pc = ^fetch_pc_i;

endmodule
